// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle IDLE/DECODE/EXEC/MEM/WB sequencer driving the top_register datapath.
// Define MEM_TIMEOUT_EN to bound the MEM wait to TIMEOUT_CYCLES cycles.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rd,
  output logic [15:0] immediate_oprand,
  output logic [4:0]  shamt,
  output logic [2:0]  alu_ctrl,
  output logic        mux_alu_b_sel,
  output logic        mux_data_in_sel,
  output logic        RegWrite,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch_taken,
  output logic        illegal_instr,
  output logic        mem_timeout
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_ready_q, instr_ready_d;
  logic [4:0]  ra_q, ra_d, rb_q, rb_d, rd_q, rd_d, shamt_q, shamt_d;
  logic [15:0] imm_q, imm_d;
  logic [2:0]  alu_q, alu_d;
  logic        bsel_q, bsel_d, dsel_q, dsel_d, regwrite_q, regwrite_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        branch_q, branch_d, illegal_q, illegal_d;

  logic        dec_legal, dec_rtype, dec_lw, dec_sw, dec_beq, dec_bsel;
  logic [2:0]  dec_alu;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
`endif

  // The latched word is decoded continuously; it is stable from DECODE through WB.
  always_comb begin
    dec_legal = 1'b1;
    dec_rtype = 1'b0;
    dec_lw    = 1'b0;
    dec_sw    = 1'b0;
    dec_beq   = 1'b0;
    dec_bsel  = 1'b1;
    dec_alu   = 3'd0;
    case (instr_q[31:26])
      6'h00: begin
        dec_rtype = 1'b1;
        dec_bsel  = 1'b0;
        case (instr_q[5:0])
          6'h20:   dec_alu = 3'd0;
          6'h22:   dec_alu = 3'd1;
          6'h24:   dec_alu = 3'd2;
          6'h25:   dec_alu = 3'd3;
          6'h2A:   dec_alu = 3'd4;
          6'h00:   dec_alu = 3'd5;
          6'h02:   dec_alu = 3'd6;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08:   dec_alu = 3'd0;
      6'h0C:   dec_alu = 3'd2;
      6'h0D:   dec_alu = 3'd3;
      6'h23:   dec_lw  = 1'b1;
      6'h2B:   dec_sw  = 1'b1;
      6'h04: begin
        dec_beq  = 1'b1;
        dec_bsel = 1'b0;
        dec_alu  = 3'd1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_ready_d = instr_ready_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    rd_d          = rd_q;
    shamt_d       = shamt_q;
    imm_d         = imm_q;
    alu_d         = alu_q;
    bsel_d        = bsel_q;
    dsel_d        = dsel_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    regwrite_d    = 1'b0;
    branch_d      = 1'b0;
    illegal_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    mem_timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_ready_q && instr_valid) begin
          instr_d       = instr;
          instr_ready_d = 1'b0;
          state_d       = S_DECODE;
        end else begin
          instr_ready_d = 1'b1;
        end
      end
      S_DECODE: begin
        ra_d    = instr_q[25:21];
        rb_d    = instr_q[20:16];
        imm_d   = instr_q[15:0];
        shamt_d = instr_q[10:6];
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          rd_d    = dec_rtype ? instr_q[15:11] : instr_q[20:16];
          alu_d   = dec_alu;
          bsel_d  = dec_bsel;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_beq) begin
          branch_d = alu_zero;
          state_d  = S_IDLE;
        end else if (dec_lw || dec_sw) begin
          mem_read_d  = dec_lw;
          mem_write_d = dec_sw;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
          state_d     = S_MEM;
        end else begin
          regwrite_d = (rd_q != 5'd0);
          dsel_d     = 1'b0;
          state_d    = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (dec_lw) begin
            regwrite_d = (rd_q != 5'd0);
            dsel_d     = 1'b1;
            state_d    = S_WB;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          mem_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b0;
      ra_q          <= '0;
      rb_q          <= '0;
      rd_q          <= '0;
      shamt_q       <= '0;
      imm_q         <= '0;
      alu_q         <= '0;
      bsel_q        <= 1'b0;
      dsel_q        <= 1'b0;
      regwrite_q    <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      mem_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_ready_q <= instr_ready_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      rd_q          <= rd_d;
      shamt_q       <= shamt_d;
      imm_q         <= imm_d;
      alu_q         <= alu_d;
      bsel_q        <= bsel_d;
      dsel_q        <= dsel_d;
      regwrite_q    <= regwrite_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      branch_q      <= branch_d;
      illegal_q     <= illegal_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
`endif
    end
  end

  assign instr_ready      = instr_ready_q;
  assign Ra               = ra_q;
  assign Rb               = rb_q;
  assign Rd               = rd_q;
  assign immediate_oprand = imm_q;
  assign shamt            = shamt_q;
  assign alu_ctrl         = alu_q;
  assign mux_alu_b_sel    = bsel_q;
  assign mux_data_in_sel  = dsel_q;
  assign RegWrite         = regwrite_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign branch_taken     = branch_q;
  assign illegal_instr    = illegal_q;
`ifdef MEM_TIMEOUT_EN
  assign mem_timeout      = mem_timeout_q;
`else
  assign mem_timeout      = 1'b0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed plus random instructions
// against a per-transaction outcome model (latency, pulse counts, decoded fields).
module tb_mips_multicycle_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [4:0]  Ra, Rb, Rd, shamt;
  logic [15:0] immediate_oprand;
  logic [2:0]  alu_ctrl;
  logic        mux_alu_b_sel, mux_data_in_sel, RegWrite, mem_read, mem_write;
  logic        branch_taken, illegal_instr, mem_timeout;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .Ra(Ra), .Rb(Rb), .Rd(Rd), .immediate_oprand(immediate_oprand), .shamt(shamt),
    .alu_ctrl(alu_ctrl), .mux_alu_b_sel(mux_alu_b_sel), .mux_data_in_sel(mux_data_in_sel),
    .RegWrite(RegWrite), .mem_read(mem_read), .mem_write(mem_write),
    .branch_taken(branch_taken), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
  );

  int total = 0;
  int bad = 0;
  int lat, rw_cnt, rd_cnt, wr_cnt, br_cnt, il_cnt, to_cnt;
  logic rw_sel;

  typedef struct {
    bit         legal;
    bit         rtype;
    bit         lw;
    bit         sw;
    bit         beq;
    logic [2:0] alu;
    bit         bsel;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    e.legal = 1; e.rtype = 0; e.lw = 0; e.sw = 0; e.beq = 0; e.alu = 3'd0; e.bsel = 1;
    case (ins[31:26])
      6'h00: begin
        e.rtype = 1; e.bsel = 0;
        case (ins[5:0])
          6'h20: e.alu = 3'd0;
          6'h22: e.alu = 3'd1;
          6'h24: e.alu = 3'd2;
          6'h25: e.alu = 3'd3;
          6'h2A: e.alu = 3'd4;
          6'h00: e.alu = 3'd5;
          6'h02: e.alu = 3'd6;
          default: e.legal = 0;
        endcase
      end
      6'h08: e.alu = 3'd0;
      6'h0C: e.alu = 3'd2;
      6'h0D: e.alu = 3'd3;
      6'h23: e.lw = 1;
      6'h2B: e.sw = 1;
      6'h04: begin e.beq = 1; e.bsel = 0; e.alu = 3'd1; end
      default: e.legal = 0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [8];
    logic [5:0] fns [7];
    logic [31:0] r;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[31:26] = ops[$urandom_range(0, 7)];
    if (r[31:26] == 6'h00 && $urandom_range(0, 9) < 8) r[5:0] = fns[$urandom_range(0, 6)];
    return r;
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctl"}, {23'd0, instr_ready, RegWrite, mem_read, mem_write, branch_taken,
                          illegal_instr, mem_timeout, mux_alu_b_sel, mux_data_in_sel}, 32'd0);
    check({pfx, "_fld"}, {9'd0, Ra, Rb, Rd, shamt, alu_ctrl}, 32'd0);
    check({pfx, "_imm"}, {16'd0, immediate_oprand}, 32'd0);
  endtask

  // One transaction: accept at a posedge, then observe each following negedge until instr_ready.
  task automatic run_txn(input logic [31:0] ins, input int n_mem, input bit az, input int limit);
    int memc;
    for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
    check($sformatf("pre_ready[%08h]", ins), {31'd0, instr_ready}, 32'd1);
    instr = ins; instr_valid = 1'b1; alu_zero = az; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    instr_valid = 1'b0; instr = $urandom;
    lat = -1; rw_cnt = 0; rd_cnt = 0; wr_cnt = 0; br_cnt = 0; il_cnt = 0; to_cnt = 0;
    rw_sel = 1'b0; memc = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (instr_ready) begin lat = c; break; end
      if (RegWrite) begin rw_cnt++; rw_sel = mux_data_in_sel; end
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (branch_taken) br_cnt++;
      if (illegal_instr) il_cnt++;
      if (mem_timeout) to_cnt++;
      if (mem_read || mem_write) begin
        memc++;
        mem_ready = (n_mem != 0 && memc == n_mem);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      instr_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
    end
    instr_valid = 1'b0; mem_ready = 1'b0;
  endtask

  // n_mem = 0 means mem_ready never arrives (only meaningful with the timeout enabled).
  task automatic do_txn(input logic [31:0] ins, input int n_mem, input bit az);
    exp_t e;
    int   n_eff, exp_lat;
    bit   timed, writes;
    logic [4:0] rd_exp;
    string s;
    e = ref_decode(ins);
    timed  = (n_mem == 0);
    n_eff  = timed ? TO : n_mem;
    rd_exp = e.rtype ? ins[15:11] : ins[20:16];
    writes = e.legal && !e.sw && !e.beq && !(e.lw && timed);
    if (!e.legal)    exp_lat = 2;
    else if (e.beq)  exp_lat = 3;
    else if (e.sw)   exp_lat = 3 + n_eff;
    else if (e.lw)   exp_lat = timed ? 3 + TO : 4 + n_eff;
    else             exp_lat = 4;
    run_txn(ins, n_mem, az, exp_lat + 10);
    s = $sformatf("%08h", ins);
    $display("txn instr=%s n_mem=%0d alu_zero=%0d latency=%0d", s, n_mem, az, lat);
    check({"latency[", s, "]"}, lat, exp_lat);
    check({"regwrite_cycles[", s, "]"}, rw_cnt, (writes && rd_exp != 0) ? 1 : 0);
    if (rw_cnt > 0) check({"data_in_sel[", s, "]"}, {31'd0, rw_sel}, {31'd0, e.lw});
    check({"mem_read_cycles[", s, "]"}, rd_cnt, (e.legal && e.lw) ? n_eff : 0);
    check({"mem_write_cycles[", s, "]"}, wr_cnt, (e.legal && e.sw) ? n_eff : 0);
    check({"branch_pulses[", s, "]"}, br_cnt, (e.legal && e.beq && az) ? 1 : 0);
    check({"illegal_pulses[", s, "]"}, il_cnt, e.legal ? 0 : 1);
    check({"timeout_pulses[", s, "]"}, to_cnt, (e.legal && (e.lw || e.sw) && timed) ? 1 : 0);
    if (e.legal) begin
      check({"Ra[", s, "]"}, {27'd0, Ra}, {27'd0, ins[25:21]});
      check({"Rb[", s, "]"}, {27'd0, Rb}, {27'd0, ins[20:16]});
      check({"Rd[", s, "]"}, {27'd0, Rd}, {27'd0, rd_exp});
      check({"imm[", s, "]"}, {16'd0, immediate_oprand}, {16'd0, ins[15:0]});
      check({"shamt[", s, "]"}, {27'd0, shamt}, {27'd0, ins[10:6]});
      check({"alu_ctrl[", s, "]"}, {29'd0, alu_ctrl}, {29'd0, e.alu});
      check({"b_sel[", s, "]"}, {31'd0, mux_alu_b_sel}, {31'd0, e.bsel});
    end
  endtask

  initial begin
    int wr_seen;
    // Reset with a valid instruction offered: nothing may be accepted.
    instr = 32'h00221820; instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    instr_valid = 1'b0; rst_n = 1'b1;
    #1 check("ready_before_edge", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, instr_ready}, 32'd1);

    do_txn(32'h00221820, 1, 1'b0);   // ADD $3,$1,$2
    do_txn(32'h8C040010, 3, 1'b0);   // LW $4,0x10($0)
    do_txn(32'h10210004, 1, 1'b1);   // BEQ taken
    do_txn(32'h10210004, 1, 1'b0);   // BEQ not taken
    do_txn(32'hFC000000, 1, 1'b0);   // opcode 0x3F
    do_txn(32'h20000005, 1, 1'b0);   // ADDI $0 (write suppressed)
    do_txn(32'hAC220008, 1, 1'b1);   // SW, ready on first MEM cycle
    do_txn(32'h00051882, 2, 1'b0);   // SRL $3,$5,2
    do_txn(32'h8C200004, 2, 1'b0);   // LW to $0
    do_txn(32'h0022183F, 1, 1'b0);   // illegal funct
`ifdef MEM_TIMEOUT_EN
    do_txn(32'hAC220008, 0, 1'b0);   // SW never acknowledged
`endif
    for (int t = 0; t < 40; t++) do_txn(rand_instr(), $urandom_range(1, 4), 1'($urandom_range(0, 1)));

    // Reset in the middle of a store: strobe drops at once and the store is not replayed.
    instr = 32'hAC220008; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    check("mid_write_before_reset", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    @(negedge clk);
    check("mid_ready_after_release", {31'd0, instr_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_write) wr_seen++;
    end
    mem_ready = 1'b0;
    check("mid_write_dropped", wr_seen, 0);
    $display("txn mid-operation reset write_cycles_after=%0d", wr_seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
